// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer
//   Multi-cycle FP32 adder controller. Takes one operand pair over a
//   valid/ready handshake, then aligns, adds and normalizes it, and holds
//   the truncated sum until the consumer takes it. Only one operation is
//   in flight at a time.
//
// Ports
//   clock         posedge clock for all state
//   reset         synchronous, active-high; aborts any operation in flight
//   in_valid      operand pair valid
//   in_ready      operands accepted this cycle (high only in IDLE)
//   in_a, in_b    IEEE-754 single operands
//   out_valid     result valid, held until out_ready
//   out_ready     consumer accepts the result
//   out_result    a + b, IEEE-754 single, truncated, denormals flushed
//   out_overflow  finite inputs overflowed to infinity
//   busy          high whenever the FSM is not idle
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// ALIGN  | unpack, resolve NaN/inf, order by magnitude, shift small operand
// ADD    | sign-magnitude add/sub, carry fix-up, overflow detect
// NORM   | one left shift per cycle until the hidden bit is set
// DONE   | result presented, waiting for out_ready

module fp_add_sequencer #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int EXP_BIAS = 127
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   busy
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] SHIFT_LIMIT = EXP_W'(MAN_W + 2);
    localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    if (EXP_BIAS != (1 << (EXP_W - 1)) - 1) begin : g_bias_check
        $error("EXP_BIAS is inconsistent with EXP_W");
    end

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
    state_t state, state_next;

    logic [W-1:0]     op_a, op_b;
    logic [MAN_W:0]   big_man, small_man, norm_man;
    logic [EXP_W-1:0] exp_r;
    logic             res_sign, eff_sub;
    logic [W-1:0]     result_q;
    logic             overflow_q;

    // ALIGN-stage decode of the captured operands
    logic [EXP_W-1:0] exp_a, exp_b, exp_diff;
    logic [MAN_W:0]   man_a, man_b, small_shifted;
    logic             sign_a, sign_b, a_big;
    logic             nan_a, nan_b, inf_a, inf_b, special;
    logic [W-1:0]     special_res;

    assign sign_a = op_a[W-1];
    assign sign_b = op_b[W-1];
    assign exp_a  = op_a[W-2:MAN_W];
    assign exp_b  = op_b[W-2:MAN_W];
    // exponent 0 means zero; denormal fractions are dropped here
    assign man_a  = (exp_a == '0) ? '0 : {1'b1, op_a[MAN_W-1:0]};
    assign man_b  = (exp_b == '0) ? '0 : {1'b1, op_b[MAN_W-1:0]};
    assign nan_a  = (exp_a == '1) && (op_a[MAN_W-1:0] != '0);
    assign nan_b  = (exp_b == '1) && (op_b[MAN_W-1:0] != '0);
    assign inf_a  = (exp_a == '1) && (op_a[MAN_W-1:0] == '0);
    assign inf_b  = (exp_b == '1) && (op_b[MAN_W-1:0] == '0);
    assign special = nan_a || nan_b || inf_a || inf_b;

    // magnitude tie keeps A as the big operand
    assign a_big    = {exp_a, man_a} >= {exp_b, man_b};
    assign exp_diff = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    assign small_shifted = (exp_diff >= SHIFT_LIMIT) ? '0
                         : ((a_big ? man_b : man_a) >> exp_diff);

    always_comb begin
        special_res = op_b;
        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b)))
            special_res = QNAN;
        else if (inf_a)
            special_res = op_a;
    end

    // ADD / NORM datapath
    logic [MAN_W+1:0] sum;
    logic [EXP_W-1:0] exp_inc, exp_dec;
    logic [MAN_W:0]   norm_shift;

    assign sum        = eff_sub ? ({1'b0, big_man} - {1'b0, small_man})
                                : ({1'b0, big_man} + {1'b0, small_man});
    assign exp_inc    = exp_r + EXP_ONE;
    assign exp_dec    = exp_r - EXP_ONE;
    assign norm_shift = norm_man << 1;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_ALIGN;
            S_ALIGN: state_next = special ? S_DONE : S_ADD;
            S_ADD: begin
                if (sum == '0 || sum[MAN_W+1] || sum[MAN_W]) state_next = S_DONE;
                else                                         state_next = S_NORM;
            end
            // an exponent of 1 cannot absorb another shift: result flushes to +0
            S_NORM:  if (exp_r <= EXP_ONE || norm_shift[MAN_W]) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // outputs decoded from state, result fields from registers
    always_comb begin
        in_ready     = (state == S_IDLE);
        out_valid    = (state == S_DONE);
        busy         = (state != S_IDLE);
        out_result   = result_q;
        out_overflow = overflow_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            big_man    <= '0;
            small_man  <= '0;
            norm_man   <= '0;
            exp_r      <= '0;
            res_sign   <= 1'b0;
            eff_sub    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a       <= in_a;
                        op_b       <= in_b;
                        overflow_q <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    if (special) result_q <= special_res;
                    exp_r     <= a_big ? exp_a : exp_b;
                    big_man   <= a_big ? man_a : man_b;
                    small_man <= small_shifted;
                    res_sign  <= a_big ? sign_a : sign_b;
                    eff_sub   <= (sign_a != sign_b);
                end
                S_ADD: begin
                    if (sum == '0) begin
                        result_q <= '0;
                    end else if (sum[MAN_W+1]) begin
                        if (exp_inc == '1) begin
                            result_q   <= {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            overflow_q <= 1'b1;
                        end else begin
                            result_q <= {res_sign, exp_inc, sum[MAN_W:1]};
                        end
                    end else if (sum[MAN_W]) begin
                        result_q <= {res_sign, exp_r, sum[MAN_W-1:0]};
                    end else begin
                        norm_man <= sum[MAN_W:0];
                    end
                end
                S_NORM: begin
                    if (exp_r <= EXP_ONE) begin
                        result_q <= '0;
                    end else begin
                        exp_r    <= exp_dec;
                        norm_man <= norm_shift;
                        if (norm_shift[MAN_W])
                            result_q <= {res_sign, exp_dec, norm_shift[MAN_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer
//   Self-checking bench for fp_add_sequencer. Expected results are hand
//   derived constants pushed to a scoreboard queue when each operand pair
//   is issued and popped when the result appears.

module tb_fp_add_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_add_sequencer #(.EXP_W(8), .MAN_W(23), .EXP_BIAS(127)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Arithmetic vectors: a, b, result, overflow, latency from accept cycle.
    localparam int N_ARITH = 9;
    localparam logic [31:0] AR_A [N_ARITH] = '{32'h3FC00000, 32'h3F800000, 32'h40400000,
        32'hBFC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h00800000};
    localparam logic [31:0] AR_B [N_ARITH] = '{32'h40200000, 32'hBF400000, 32'hC0400000,
        32'hC0200000, 32'h3F800000, 32'h00000000, 32'h30800000, 32'hBF800000, 32'h80C00000};
    localparam logic [31:0] AR_R [N_ARITH] = '{32'h40800000, 32'h3E800000, 32'h00000000,
        32'hC0800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h34000000, 32'h00000000};
    localparam int AR_L [N_ARITH] = '{3, 5, 3, 3, 3, 3, 3, 26, 4};

    localparam int N_SPEC = 5;
    localparam logic [31:0] SP_A [N_SPEC] = '{32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000,
        32'h7F800000, 32'hFF800000};
    localparam logic [31:0] SP_B [N_SPEC] = '{32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
        32'h3F800000, 32'hFF800000};
    localparam logic [31:0] SP_R [N_SPEC] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000,
        32'h7F800000, 32'hFF800000};
    localparam logic SP_O [N_SPEC] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int   SP_L [N_SPEC] = '{3, 2, 2, 2, 2};

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Issues one pair (in_ready must already be high) and returns at the
    // first cycle out_valid is seen. Latency counts the accepting edge as 1.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [31:0] res,
                            output logic ovf, output logic bsy, output bit timed_out);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
        timed_out = !out_valid;
        res = out_result;
        ovf = out_overflow;
        bsy = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h3F800000;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        reset = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, busy, out_overflow} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/vld/busy/ovf=%b expected 1000",
                     {in_ready, out_valid, busy, out_overflow});
        end
        n_cmp++;
        if (out_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h expected 00000000", out_result);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_capture: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_arith();
        int lat; logic [31:0] res; logic ovf, bsy; bit to; exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < N_ARITH; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL arith%0d_in_ready: got %b expected 1", i, in_ready);
            end
            sb.push_back('{res: AR_R[i], ovf: 1'b0, lat: AR_L[i]});
            drive_op(AR_A[i], AR_B[i], lat, res, ovf, bsy, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL arith%0d_timeout: no out_valid within %0d cycles", i, lat);
                apply_reset();
                continue;
            end
            if (res !== e.res) begin
                n_err++;
                $display("FAIL arith%0d_result: got %h expected %h", i, res, e.res);
            end
            n_cmp++;
            if (ovf !== e.ovf) begin
                n_err++;
                $display("FAIL arith%0d_overflow: got %b expected %b", i, ovf, e.ovf);
            end
            n_cmp++;
            if (lat != e.lat) begin
                n_err++;
                $display("FAIL arith%0d_latency: got %0d expected %0d", i, lat, e.lat);
            end
            n_cmp++;
            if (bsy !== 1'b1) begin
                n_err++;
                $display("FAIL arith%0d_busy: got %b expected 1", i, bsy);
            end
            @(posedge clock); #1;
            n_cmp++;
            if ({out_valid, in_ready, busy} !== 3'b010) begin
                n_err++;
                $display("FAIL arith%0d_after_handshake: vld/rdy/busy got %b expected 010",
                         i, {out_valid, in_ready, busy});
            end
        end
    endtask

    task automatic test_specials();
        int lat; logic [31:0] res; logic ovf, bsy; bit to; exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < N_SPEC; i++) begin
            sb.push_back('{res: SP_R[i], ovf: SP_O[i], lat: SP_L[i]});
            drive_op(SP_A[i], SP_B[i], lat, res, ovf, bsy, to);
            e = sb.pop_front();
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL spec%0d_timeout: no out_valid within %0d cycles", i, lat);
                apply_reset();
                continue;
            end
            if (res !== e.res) begin
                n_err++;
                $display("FAIL spec%0d_result: got %h expected %h", i, res, e.res);
            end
            n_cmp++;
            if (ovf !== e.ovf) begin
                n_err++;
                $display("FAIL spec%0d_overflow: got %b expected %b", i, ovf, e.ovf);
            end
            n_cmp++;
            if (lat != e.lat) begin
                n_err++;
                $display("FAIL spec%0d_latency: got %0d expected %0d", i, lat, e.lat);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] res; logic ovf, bsy; bit to; exp_t e;
        out_ready = 1'b0;
        sb.push_back('{res: 32'h40800000, ovf: 1'b0, lat: 3});
        drive_op(32'h3FC00000, 32'h40200000, lat, res, ovf, bsy, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || res !== e.res || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_first_result: got %h lat %0d expected %h lat %0d",
                     res, lat, e.res, e.lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_a = 32'h41000000 + 32'(i);
            in_b = 32'hC1100000;
            in_valid = 1'b1;
            @(posedge clock); #1;
            n_cmp++;
            if ({out_valid, in_ready, busy} !== 3'b101 || out_result !== e.res) begin
                n_err++;
                $display("FAIL bp_hold%0d: vld/rdy/busy %b result %h expected 101 result %h",
                         i, {out_valid, in_ready, busy}, out_result, e.res);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        n_cmp++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL bp_release: vld/rdy/busy got %b expected 010",
                     {out_valid, in_ready, busy});
        end
        @(posedge clock); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_capture: busy got %b expected 0", busy);
        end
        sb.push_back('{res: 32'h40000000, ovf: 1'b0, lat: 3});
        drive_op(32'h3F800000, 32'h3F800000, lat, res, ovf, bsy, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || res !== e.res || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_next_op: got %h lat %0d expected %h lat %0d",
                     res, lat, e.res, e.lat);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [31:0] res; logic ovf, bsy; bit to; exp_t e;
        out_ready = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'hBF400000;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({out_valid, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_in_norm: vld/busy got %b expected 01", {out_valid, busy});
        end
        apply_reset();
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL mid_after_reset: vld/busy/rdy got %b expected 001",
                     {out_valid, busy, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL mid_discard%0d: out_valid got %b expected 0", i, out_valid);
            end
        end
        sb.push_back('{res: 32'h40800000, ovf: 1'b0, lat: 3});
        drive_op(32'h3FC00000, 32'h40200000, lat, res, ovf, bsy, to);
        e = sb.pop_front();
        n_cmp++;
        if (to || res !== e.res || ovf !== e.ovf || lat != e.lat) begin
            n_err++;
            $display("FAIL mid_next_op: got %h ovf %b lat %0d expected %h ovf %b lat %0d",
                     res, ovf, lat, e.res, e.ovf, e.lat);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_arith();
        test_specials();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
